// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intr_pkg
//  Description : Shared constants, FSM state type and vector helper for the
//                interrupt scheduler.
//                NDEV       - number of device request lines
//                PRI_W      - priority field width (device PSW[7:5])
//                IDX_W      - width of a device index
//                VEC_BASE   - vector low byte of device 0
//                VEC_STRIDE - vector spacing between consecutive devices
//  Revision    : 1.0  initial release
// ============================================================================
package intr_pkg;

    localparam int         NDEV       = 8;
    localparam int         PRI_W      = 3;
    localparam int         IDX_W      = $clog2(NDEV);
    localparam logic [7:0] VEC_BASE   = 8'h02;
    localparam int         VEC_STRIDE = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Vector low byte for a device index; wraps modulo 256 by construction.
    function automatic logic [7:0] vec_of(input logic [IDX_W-1:0] idx);
        vec_of = VEC_BASE + 8'(VEC_STRIDE) * 8'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pri_stack
//  Description : LIFO of interrupt priorities used for nesting.
//                clk, rst_n  - clock, asynchronous active-low reset
//                push        - store push_data on top
//                pop         - discard top entry (ignored when empty)
//                push_data   - priority to push
//                top         - raw top entry (meaningless when empty)
//                full/empty  - occupancy flags
//                underflow   - pop requested while empty (combinational)
//                A simultaneous push and pop on a non-empty stack replaces
//                the top entry, leaving the depth unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module pri_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             underflow
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_cnt_w-1:0]  r_count;
    logic                w_do_pop;
    logic [c_addr_w-1:0] w_top_idx;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign underflow = pop & empty;
    assign w_do_pop  = pop & ~empty;
    assign w_top_idx = c_addr_w'(r_count - 1'b1);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push && w_do_pop) begin
                // pop-then-push collapses to an overwrite of the top entry
                r_mem[w_top_idx] <= push_data;
            end else if (push && !full) begin
                r_mem[c_addr_w'(r_count)] <= push_data;
                r_count                   <= r_count + 1'b1;
            end else if (w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_scheduler
//  Description : Latches device interrupt requests, acknowledges them, and
//                presents the highest-priority request above the current
//                execution priority to the CPU via an irq/irq_take handshake.
//                Accepted priorities are stacked for nesting; RETI pops.
//                clk, rst_n   - clock, asynchronous active-low reset
//                dev_req      - level requests, rising edge captured
//                dev_pri_cfg  - per-device priority, 3 bits per device
//                cpu_pri      - CPU current PSW priority
//                irq_take     - CPU accepts the presented interrupt
//                reti         - CPU executed RETI
//                dev_ack      - one-cycle acknowledge per captured edge
//                irq/vector/irq_pri - presented request
//                active_pri   - top of priority stack, 0 when empty
//                stack_err    - sticky RETI-on-empty flag
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_scheduler
    import intr_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NDEV-1:0]       dev_req,
    input  logic [NDEV*PRI_W-1:0] dev_pri_cfg,
    input  logic [PRI_W-1:0]      cpu_pri,
    input  logic                  irq_take,
    input  logic                  reti,
    output logic [NDEV-1:0]       dev_ack,
    output logic                  irq,
    output logic [7:0]            vector,
    output logic [PRI_W-1:0]      irq_pri,
    output logic [PRI_W-1:0]      active_pri,
    output logic                  stack_err
);

    logic [NDEV-1:0]  r_req_d;
    logic [NDEV-1:0]  r_pending;
    logic [NDEV-1:0]  r_dev_ack;
    logic [PRI_W-1:0] r_pri_q [NDEV];
    state_t           r_state;
    logic [IDX_W-1:0] r_sel;
    logic             r_irq;
    logic [7:0]       r_vector;
    logic [PRI_W-1:0] r_irq_pri;
    logic             r_stack_err;

    logic [NDEV-1:0]  w_rise;
    logic [NDEV-1:0]  w_clr;
    logic [NDEV-1:0]  w_eligible;
    logic [PRI_W-1:0] w_top;
    logic [PRI_W-1:0] w_active_pri;
    logic [PRI_W-1:0] w_cur_pri;
    logic             w_take;
    logic             w_full;
    logic             w_empty;
    logic             w_underflow;
    logic             w_any;
    logic [IDX_W-1:0] w_win_idx;
    logic [PRI_W-1:0] w_win_pri;

    assign w_rise       = dev_req & ~r_req_d;
    // a take only counts while a request is actually on the outputs
    assign w_take       = irq_take & r_irq;
    // clear the device visible on the outputs, not a same-cycle new winner
    assign w_clr        = w_take ? (NDEV'(1) << r_sel) : '0;
    assign w_active_pri = w_empty ? '0 : w_top;
    assign w_cur_pri    = (cpu_pri > w_active_pri) ? cpu_pri : w_active_pri;

    for (genvar gi = 0; gi < NDEV; gi++) begin : g_elig
        assign w_eligible[gi] = r_pending[gi] & (r_pri_q[gi] > w_cur_pri);
    end

    // Highest priority wins; strict compare keeps ties on the lowest index.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_pri = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (w_eligible[i] && (!w_any || (r_pri_q[i] > w_win_pri))) begin
                w_any     = 1'b1;
                w_win_idx = IDX_W'(i);
                w_win_pri = r_pri_q[i];
            end
        end
    end

    // Request capture. A re-edge on a still-pending device is acknowledged
    // but keeps the priority sampled at its original capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_dev_ack <= '0;
            for (int i = 0; i < NDEV; i++) begin
                r_pri_q[i] <= '0;
            end
        end else begin
            r_req_d   <= dev_req;
            r_dev_ack <= w_rise;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            for (int i = 0; i < NDEV; i++) begin
                if (w_rise[i] && !(r_pending[i] && !w_clr[i])) begin
                    r_pri_q[i] <= dev_pri_cfg[i*PRI_W +: PRI_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_irq       <= 1'b0;
            r_vector    <= '0;
            r_irq_pri   <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_underflow) begin
                r_stack_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !w_full) begin
                        r_state   <= ST_PRESENT;
                        r_irq     <= 1'b1;
                        r_sel     <= w_win_idx;
                        r_vector  <= vec_of(w_win_idx);
                        r_irq_pri <= w_win_pri;
                    end
                end
                ST_PRESENT: begin
                    if (w_take) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end else if (!w_any) begin
                        // masked by a raised cpu_pri; request stays pending
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end else begin
                        r_sel     <= w_win_idx;
                        r_vector  <= vec_of(w_win_idx);
                        r_irq_pri <= w_win_pri;
                    end
                end
            endcase
        end
    end

    pri_stack #(
        .DEPTH (DEPTH),
        .WIDTH (PRI_W)
    ) u_pri_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_take),
        .pop       (reti),
        .push_data (r_irq_pri),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty),
        .underflow (w_underflow)
    );

    assign dev_ack    = r_dev_ack;
    assign irq        = r_irq;
    assign vector     = r_vector;
    assign irq_pri    = r_irq_pri;
    assign active_pri = w_active_pri;
    assign stack_err  = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_scheduler
//  Description : Self-checking bench for interrupt_scheduler. Each row holds
//                one cycle of stimulus plus the outputs expected after the
//                following rising edge; expected rows go through a queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_scheduler;
    import intr_pkg::*;

    typedef struct {
        logic [7:0]       req;
        logic [PRI_W-1:0] cpu;
        logic             take;
        logic             ret;
        logic             irq;
        logic [7:0]       vec;
        logic [PRI_W-1:0] ipri;
        logic [PRI_W-1:0] act;
        logic [7:0]       ack;
        logic             err;
    } row_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NDEV-1:0]       dev_req;
    logic [NDEV*PRI_W-1:0] dev_pri_cfg;
    logic [PRI_W-1:0]      cpu_pri;
    logic                  irq_take;
    logic                  reti;
    logic [NDEV-1:0]       dev_ack;
    logic                  irq;
    logic [7:0]            vector;
    logic [PRI_W-1:0]      irq_pri;
    logic [PRI_W-1:0]      active_pri;
    logic                  stack_err;

    int   checks = 0;
    int   errors = 0;
    row_t exp_q [$];
    row_t vecs  [$];
    logic [PRI_W-1:0] pri_tab [NDEV];

    always #5 clk = ~clk;

    interrupt_scheduler #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dev_req     (dev_req),
        .dev_pri_cfg (dev_pri_cfg),
        .cpu_pri     (cpu_pri),
        .irq_take    (irq_take),
        .reti        (reti),
        .dev_ack     (dev_ack),
        .irq         (irq),
        .vector      (vector),
        .irq_pri     (irq_pri),
        .active_pri  (active_pri),
        .stack_err   (stack_err)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1);
    end

    function automatic row_t mk(input logic [7:0] req, input logic [2:0] cpu,
                                input logic take, input logic ret,
                                input logic e_irq, input logic [7:0] e_vec,
                                input logic [2:0] e_ipri, input logic [2:0] e_act,
                                input logic [7:0] e_ack, input logic e_err);
        row_t r;
        r.req = req;  r.cpu = cpu;   r.take = take;  r.ret = ret;
        r.irq = e_irq; r.vec = e_vec; r.ipri = e_ipri; r.act = e_act;
        r.ack = e_ack; r.err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic load_cfg();
        for (int i = 0; i < NDEV; i++) begin
            dev_pri_cfg[i*PRI_W +: PRI_W] = pri_tab[i];
        end
    endtask

    task automatic compare_front(input string tag);
        row_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".irq"},        8'(irq),        8'(e.irq));
        chk({tag, ".vector"},     vector,         e.vec);
        chk({tag, ".irq_pri"},    8'(irq_pri),    8'(e.ipri));
        chk({tag, ".active_pri"}, 8'(active_pri), 8'(e.act));
        chk({tag, ".dev_ack"},    dev_ack,        e.ack);
        chk({tag, ".stack_err"},  8'(stack_err),  8'(e.err));
    endtask

    task automatic apply(input row_t r, input string tag);
        dev_req  = r.req;
        cpu_pri  = r.cpu;
        irq_take = r.take;
        reti     = r.ret;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        compare_front(tag);
    endtask

    initial begin
        pri_tab = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6};
        load_cfg();
        rst_n = 1'b0; dev_req = '0; cpu_pri = '0; irq_take = 1'b0; reti = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.irq", 8'(irq), 8'd0);
        chk("reset.vector", vector, 8'd0);
        chk("reset.irq_pri", 8'(irq_pri), 8'd0);
        chk("reset.active_pri", 8'(active_pri), 8'd0);
        chk("reset.dev_ack", dev_ack, 8'd0);
        chk("reset.stack_err", 8'(stack_err), 8'd0);
        rst_n = 1'b1;

        // single device, then equal-priority pair with masking by active_pri
        //          req    cpu take ret  irq vec    pri act ack    err
        vecs.push_back(mk(8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h04, 0, 0, 0,  0, 8'h00, 0, 0, 8'h04, 0));
        vecs.push_back(mk(8'h04, 0, 0, 0,  1, 8'h0A, 4, 0, 8'h00, 0));
        vecs.push_back(mk(8'h04, 0, 1, 0,  0, 8'h0A, 4, 4, 8'h00, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0,  0, 8'h0A, 4, 4, 8'h00, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1,  0, 8'h0A, 4, 0, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 0, 0,  0, 8'h0A, 4, 0, 8'h22, 0));
        vecs.push_back(mk(8'h22, 0, 0, 0,  1, 8'h06, 3, 0, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 1, 0,  0, 8'h06, 3, 3, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 0, 0,  0, 8'h06, 3, 3, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 0, 1,  0, 8'h06, 3, 0, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 0, 0,  1, 8'h16, 3, 0, 8'h00, 0));
        vecs.push_back(mk(8'h22, 0, 1, 0,  0, 8'h16, 3, 3, 8'h00, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1,  0, 8'h16, 3, 0, 8'h00, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // nesting and RETI underflow
        apply(mk(8'h01, 0, 0, 0, 0, 8'h16, 3, 0, 8'h01, 0), "nest1");
        apply(mk(8'h01, 0, 0, 0, 1, 8'h02, 2, 0, 8'h00, 0), "nest2");
        apply(mk(8'h01, 0, 1, 0, 0, 8'h02, 2, 2, 8'h00, 0), "nest3");
        apply(mk(8'h81, 0, 0, 0, 0, 8'h02, 2, 2, 8'h80, 0), "nest4");
        apply(mk(8'h81, 0, 0, 0, 1, 8'h1E, 6, 2, 8'h00, 0), "nest5");
        apply(mk(8'h81, 0, 1, 0, 0, 8'h1E, 6, 6, 8'h00, 0), "nest6");
        apply(mk(8'h81, 0, 0, 1, 0, 8'h1E, 6, 2, 8'h00, 0), "nest7");
        apply(mk(8'h81, 0, 0, 1, 0, 8'h1E, 6, 0, 8'h00, 0), "nest8");
        apply(mk(8'h00, 0, 0, 1, 0, 8'h1E, 6, 0, 8'h00, 1), "nest9");
        apply(mk(8'h00, 0, 0, 0, 0, 8'h1E, 6, 0, 8'h00, 1), "nest10");

        // preemption of a presented request
        apply(mk(8'h10, 0, 0, 0, 0, 8'h1E, 6, 0, 8'h10, 1), "pre1");
        apply(mk(8'h10, 0, 0, 0, 1, 8'h12, 3, 0, 8'h00, 1), "pre2");
        apply(mk(8'h50, 0, 0, 0, 1, 8'h12, 3, 0, 8'h40, 1), "pre3");
        apply(mk(8'h50, 0, 0, 0, 1, 8'h1A, 5, 0, 8'h00, 1), "pre4");
        apply(mk(8'h50, 0, 1, 0, 0, 8'h1A, 5, 5, 8'h00, 1), "pre5");
        apply(mk(8'h50, 0, 0, 0, 0, 8'h1A, 5, 5, 8'h00, 1), "pre6");
        apply(mk(8'h50, 0, 0, 1, 0, 8'h1A, 5, 0, 8'h00, 1), "pre7");
        apply(mk(8'h50, 0, 0, 0, 1, 8'h12, 3, 0, 8'h00, 1), "pre8");
        apply(mk(8'h50, 0, 1, 0, 0, 8'h12, 3, 3, 8'h00, 1), "pre9");
        apply(mk(8'h00, 0, 0, 1, 0, 8'h12, 3, 0, 8'h00, 1), "pre10");

        // masking by cpu_pri
        apply(mk(8'h08, 0, 0, 0, 0, 8'h12, 3, 0, 8'h08, 1), "mask1");
        apply(mk(8'h08, 0, 0, 0, 1, 8'h0E, 2, 0, 8'h00, 1), "mask2");
        apply(mk(8'h08, 5, 0, 0, 0, 8'h0E, 2, 0, 8'h00, 1), "mask3");
        apply(mk(8'h08, 5, 0, 0, 0, 8'h0E, 2, 0, 8'h00, 1), "mask4");
        apply(mk(8'h08, 0, 0, 0, 1, 8'h0E, 2, 0, 8'h00, 1), "mask5");
        apply(mk(8'h08, 0, 1, 0, 0, 8'h0E, 2, 2, 8'h00, 1), "mask6");
        apply(mk(8'h00, 0, 0, 1, 0, 8'h0E, 2, 0, 8'h00, 1), "mask7");

        // priority 0 never eligible; later cfg change does not touch it
        pri_tab[0] = 3'd0;
        load_cfg();
        apply(mk(8'h01, 0, 0, 0, 0, 8'h0E, 2, 0, 8'h01, 1), "pri0_1");
        apply(mk(8'h01, 0, 0, 0, 0, 8'h0E, 2, 0, 8'h00, 1), "pri0_2");
        pri_tab[0] = 3'd2;
        load_cfg();
        apply(mk(8'h01, 0, 0, 0, 0, 8'h0E, 2, 0, 8'h00, 1), "pri0_3");
        apply(mk(8'h01, 0, 0, 0, 0, 8'h0E, 2, 0, 8'h00, 1), "pri0_4");

        // take and reti in the same cycle replace the top entry
        apply(mk(8'h05, 0, 0, 0, 0, 8'h0E, 2, 0, 8'h04, 1), "swap1");
        apply(mk(8'h05, 0, 0, 0, 1, 8'h0A, 4, 0, 8'h00, 1), "swap2");
        apply(mk(8'h05, 0, 1, 0, 0, 8'h0A, 4, 4, 8'h00, 1), "swap3");
        apply(mk(8'h85, 0, 0, 0, 0, 8'h0A, 4, 4, 8'h80, 1), "swap4");
        apply(mk(8'h85, 0, 0, 0, 1, 8'h1E, 6, 4, 8'h00, 1), "swap5");
        apply(mk(8'h85, 0, 1, 1, 0, 8'h1E, 6, 6, 8'h00, 1), "swap6");
        apply(mk(8'h85, 0, 0, 1, 0, 8'h1E, 6, 0, 8'h00, 1), "swap7");
        apply(mk(8'h01, 0, 0, 0, 0, 8'h1E, 6, 0, 8'h00, 1), "swap8");

        // asynchronous reset while device 3 is presented
        apply(mk(8'h09, 0, 0, 0, 0, 8'h1E, 6, 0, 8'h08, 1), "arst1");
        apply(mk(8'h09, 0, 0, 0, 1, 8'h0E, 2, 0, 8'h00, 1), "arst2");
        #2;
        dev_req = '0;
        rst_n   = 1'b0;
        #1;
        chk("arst.irq", 8'(irq), 8'd0);
        chk("arst.vector", vector, 8'd0);
        chk("arst.irq_pri", 8'(irq_pri), 8'd0);
        chk("arst.active_pri", 8'(active_pri), 8'd0);
        chk("arst.stack_err", 8'(stack_err), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(mk(8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0), $sformatf("post_rst%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_scheduler.md
Name: interrupt_scheduler

Overview:
Clocked interrupt scheduler between the eight device request lines and the CPU interrupt-entry sequence. It latches device requests and acknowledges each device. It selects the highest-priority pending request whose priority exceeds the current execution priority, and presents it to the CPU with a vector and priority using an irq/irq_take handshake. A priority stack supports nested interrupts and is popped on RETI.

Parameters:
NDEV, 8, number of device request lines
PRI_W, 3, priority field width (device PSW bits [7:5])
DEPTH, 8, priority stack depth
VEC_BASE, 8'h02, vector low byte for device 0
VEC_STRIDE, 4, vector spacing; device i vector = VEC_BASE + VEC_STRIDE*i (8'h02, 8'h06, ... 8'h1E)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dev_req  in  NDEV  device interrupt request, level; captured on rising edge
dev_pri_cfg  in  NDEV*PRI_W  per-device priority; bits [3i+2:3i] = device i PSW[7:5]
cpu_pri  in  PRI_W  CPU current PSW priority
irq_take  in  1  one-cycle pulse: CPU accepts presented interrupt
reti  in  1  one-cycle pulse: CPU executed RETI
dev_ack  out  NDEV  one-cycle acknowledge pulse per device
irq  out  1  interrupt request to CPU
vector  out  8  vector low byte of presented request
irq_pri  out  PRI_W  priority of presented request
active_pri  out  PRI_W  top of priority stack (0 when empty)
stack_err  out  1  sticky: RETI with empty stack

Behaviour:
- Reset (async, rst_n=0): irq=0, vector=0, irq_pri=0, dev_ack=0, active_pri=0, stack_err=0, pending=0, req_d=0, stack empty, FSM=IDLE.
- Capture: req_d registers dev_req. pending[i] is set when dev_req[i] & ~req_d[i] (rising edge). dev_ack[i] pulses 1 cycle later, for exactly one cycle. An edge on an already-pending device is acknowledged but not double-counted.
- The priority for device i is sampled from dev_pri_cfg at capture and held in pri_q[i]. Later cfg changes do not affect a pending request.
- cur_pri = max(cpu_pri, active_pri). eligible[i] = pending[i] & (pri_q[i] > cur_pri), strictly greater. Priority 0 is never eligible.
- Arbitration is combinational over eligible: highest pri_q wins; ties go to the lowest index.
- FSM IDLE: if any eligible and stack not full -> PRESENT. Register sel, vector and irq_pri from the winner. irq=1 from the next cycle.
- FSM PRESENT: re-arbitrate every cycle and update sel/vector/irq_pri when the winner changes, so a higher-priority arrival preempts the presentation.
  - If eligible becomes 0 (cpu_pri raised), irq=0 -> IDLE. The request stays pending.
  - On irq_take=1: clear pending[sel] using the registered sel currently visible on the outputs, not a same-cycle new winner. Push irq_pri and drop irq next cycle -> IDLE.
  - IDLE forces at least one cycle with irq=0 between presentations.
- irq_take while irq=0: ignored.
- reti: pop stack; active_pri becomes the new top, or 0 if empty. reti on empty stack sets stack_err (cleared only by reset) and has no other effect.
- irq_take and reti in the same cycle: pop first, then push. Depth is unchanged and the top is replaced by irq_pri.
- Stack full (DEPTH entries): no new presentation from IDLE. Nesting is strictly increasing, so at most 7 levels are reachable when PRI_W=3.
- A capture in the same cycle as a take for the same device: the take clears and the capture sets, so pending stays 1 (new request).
- Latency: rising dev_req at edge N -> pending at N+1 -> irq=1 at N+2 (IDLE, eligible).
- Widths: vector computed modulo 8 bits. Priority compares are unsigned PRI_W.

Decomposition:
- Shared package intr_pkg: PRI_W, NDEV, VEC_BASE, VEC_STRIDE, FSM state enum (ST_IDLE, ST_PRESENT), and a vector function vec_of(idx).
- One natural sub-module: pri_stack (push/pop/top/full/empty/underflow, DEPTH x PRI_W). The arbiter stays inline.

Test Plan:
- Reset mid-PRESENT (device 3 presented, rst_n low 1 cycle) -> irq=0, pending=0, active_pri=0 immediately (async).
- Device 2, pri 4, cpu_pri 0: rise at edge N -> dev_ack=8'h04 pulse at N+1; irq=1, vector=8'h0A, irq_pri=4 at N+2; irq_take -> irq=0, active_pri=4.
- Devices 1 and 5 both pri 3, rising together -> device 1 presented first (vector 8'h06). After take, device 5 is not presented (3 not > 3) until reti, then vector 8'h16.
- Nesting: device 0 pri 2 taken (active_pri=2); device 7 pri 6 rises -> presented (vector 8'h1E). Take -> active_pri=6. reti -> 2; reti -> 0; third reti -> stack_err=1.
- Preemption: device 4 pri 3 presented, no take; device 6 pri 5 rises -> outputs switch to vector 8'h1A, irq_pri=5 while irq stays 1. Take clears device 6 only.
- Masking: device 3 pri 2 presented, cpu_pri raised to 5 -> irq drops next cycle, pending kept. cpu_pri back to 0 -> re-presented with vector 8'h0E.
